// File: rtl/scan_pkg.sv
`default_nettype none
//============================================================================
// Module      : scan_pkg
// Description : Shared definitions for the scan index generator: FSM state
//               encoding, index bounds and the modulo-8 index stepping
//               helper used by the top level.
// Revision    : 1.0 - initial release
//============================================================================
package scan_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    localparam logic [2:0] IDX_MAX = 3'd7;
    localparam logic [2:0] IDX_MIN = 3'd0;

    // 3-bit arithmetic wraps on its own, giving 7->0 ascending and
    // 0->7 descending without extra compare logic.
    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic       down);
        return down ? (idx - 3'd1) : (idx + 3'd1);
    endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/dwell_tick.sv
`default_nettype none
//============================================================================
// Module      : dwell_tick
// Description : Dwell prescaler. Counts 0..DIV-1 on every non-hold cycle and
//               flags the terminal count so the index advances once per DIV
//               active clocks.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous clear, keeps the count at 0
//               hold - freezes the count, suppresses tick
//               tick - terminal count (count = DIV-1, hold low, not clearing)
// Revision    : 1.0 - initial release
//============================================================================
module dwell_tick #(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam logic [CNT_W-1:0] c_term = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_term;

    assign w_at_term = (cnt_q == c_term);
    assign tick      = w_at_term && !hold && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = w_at_term ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : dwell_tick
`default_nettype wire

// File: rtl/scan_index_gen.sv
`default_nettype none
//============================================================================
// Module      : scan_index_gen
// Description : Index sequencer feeding a 3-to-8 one-hot decoder. Supports
//               continuous scan in either direction and one-shot 8-index
//               sweeps, each index dwelling DIV non-hold clocks.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous active-high reset
//               en    - level, continuous scan request
//               dir   - 0 ascending, 1 descending
//               start - pulse, request one full sweep (IDLE only)
//               hold  - level, freezes dwell count and X
//               X     - current index (registered)
//               valid - X is an active scan index
//               step  - pulse in the cycle X takes a new value
//               done  - pulse after the last index of a sweep
//               busy  - high while sweeping
// Revision    : 1.0 - initial release
//============================================================================
module scan_index_gen
    import scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       start,
    input  logic       hold,
    output logic [2:0] X,
    output logic       valid,
    output logic       step,
    output logic       done,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic       sweep_dir_q, sweep_dir_d;
    logic       valid_q, valid_d;
    logic       step_q, step_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       w_tick;
    logic       w_clr;
    logic [2:0] w_sweep_last;

    // Holding the prescaler clear while idle guarantees it reads 0 in the
    // first active cycle after any entry, regardless of how it was left.
    assign w_clr = (state_q == ST_IDLE);

    dwell_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .hold (hold),
        .tick (w_tick)
    );

    assign w_sweep_last = sweep_dir_q ? IDX_MIN : IDX_MAX;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        sweep_dir_d = sweep_dir_q;
        step_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SWEEP;
                    sweep_dir_d = dir;
                    x_d         = dir ? IDX_MAX : IDX_MIN;
                    step_d      = 1'b1;
                end else if (en) begin
                    // Scan resumes from whatever index was left on X.
                    state_d = ST_SCAN;
                    step_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                // Dropping en wins over a coincident terminal count.
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    x_d    = next_index(x_q, dir);
                    step_d = 1'b1;
                end
            end

            ST_SWEEP: begin
                // start/en/dir are deliberately not looked at here.
                if (w_tick) begin
                    if (x_q == w_sweep_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d    = next_index(x_q, sweep_dir_q);
                        step_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d != ST_IDLE);
        busy_d  = (state_d == ST_SWEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= IDX_MIN;
            sweep_dir_q <= 1'b0;
            valid_q     <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            sweep_dir_q <= sweep_dir_d;
            valid_q     <= valid_d;
            step_q      <= step_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign X     = x_q;
    assign valid = valid_q;
    assign step  = step_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule : scan_index_gen
`default_nettype wire

// File: tb/tb_scan_index_gen.sv
`default_nettype none
//============================================================================
// Module      : tb_scan_index_gen
// Description : Self-checking bench for scan_index_gen. Two instances
//               (DIV=4 and DIV=1) share one stimulus stream; a behavioural
//               model predicts every output each cycle, and directed
//               scenarios pin the model with hand-derived expectations.
// Revision    : 1.0 - initial release
//============================================================================
module tb_scan_index_gen;

    localparam int DIVS [2] = '{4, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, dir = 1'b0, start = 1'b0, hold = 1'b0;

    logic [2:0] dx     [2];
    logic       dvalid [2];
    logic       dstep  [2];
    logic       ddone  [2];
    logic       dbusy  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_index_gen #(.DIV(4), .CNT_W(16)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .start(start), .hold(hold),
        .X(dx[0]), .valid(dvalid[0]), .step(dstep[0]), .done(ddone[0]), .busy(dbusy[0])
    );

    scan_index_gen #(.DIV(1), .CNT_W(16)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .start(start), .hold(hold),
        .X(dx[1]), .valid(dvalid[1]), .step(dstep[1]), .done(ddone[1]), .busy(dbusy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. mode: 0 idle, 1 scan, 2 sweep.
    // Scan: 'age' counts non-hold cycles spent on the current index.
    // Sweep: 'elapsed' counts non-hold cycles since the sweep began; the
    // index is simply elapsed/DIV counted from the starting end.
    // ------------------------------------------------------------------
    int m_mode [2] = '{0, 0};
    int m_idx  [2] = '{0, 0};
    int m_age  [2] = '{0, 0};
    int m_el   [2] = '{0, 0};
    int m_sdir [2] = '{0, 0};
    int e_x    [2] = '{0, 0};
    bit e_valid[2] = '{0, 0};
    bit e_step [2] = '{0, 0};
    bit e_done [2] = '{0, 0};
    bit e_busy [2] = '{0, 0};

    task automatic model_step(input int m);
        int div;
        div = DIVS[m];
        e_step[m] = 1'b0;
        e_done[m] = 1'b0;
        if (rst) begin
            m_mode[m] = 0; m_idx[m] = 0; m_age[m] = 0; m_el[m] = 0; m_sdir[m] = 0;
        end else begin
            case (m_mode[m])
                0: begin
                    if (start) begin
                        m_mode[m] = 2; m_sdir[m] = int'(dir); m_el[m] = 0;
                        m_idx[m]  = dir ? 7 : 0;
                        e_step[m] = 1'b1;
                    end else if (en) begin
                        m_mode[m] = 1; m_age[m] = 0;
                        e_step[m] = 1'b1;
                    end
                end
                1: begin
                    if (!en) begin
                        m_mode[m] = 0;
                    end else if (!hold) begin
                        m_age[m]++;
                        if (m_age[m] == div) begin
                            m_age[m]  = 0;
                            m_idx[m]  = (m_idx[m] + (dir ? 7 : 1)) % 8;
                            e_step[m] = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!hold) begin
                        m_el[m]++;
                        if (m_el[m] == 8 * div) begin
                            m_mode[m] = 0;
                            e_done[m] = 1'b1;
                        end else if (m_el[m] % div == 0) begin
                            m_idx[m]  = (m_sdir[m] != 0) ? 7 - m_el[m] / div : m_el[m] / div;
                            e_step[m] = 1'b1;
                        end
                    end
                end
            endcase
        end
        e_x[m]     = m_idx[m];
        e_valid[m] = (m_mode[m] != 0);
        e_busy[m]  = (m_mode[m] == 2);
    endtask

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) model_step(m);
    end

    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "X_div4"     : "X_div1",     32'(dx[m]),     32'(e_x[m]));
            chk(m == 0 ? "valid_div4" : "valid_div1", 32'(dvalid[m]), 32'(e_valid[m]));
            chk(m == 0 ? "step_div4"  : "step_div1",  32'(dstep[m]),  32'(e_step[m]));
            chk(m == 0 ? "done_div4"  : "done_div1",  32'(ddone[m]),  32'(e_done[m]));
            chk(m == 0 ? "busy_div4"  : "busy_div1",  32'(dbusy[m]),  32'(e_busy[m]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: directed scenarios, then randomized traffic.
    // Inputs change on the falling edge; samples are taken there too.
    // ------------------------------------------------------------------
    initial begin : stim
        int nv, nd, ns, dpos, phase, hc, found;
        int prev;
        bit wrap_up, wrap_dn;

        repeat (2) @(negedge clk);
        chk("reset_X",     32'(dx[0]),     0);
        chk("reset_valid", 32'(dvalid[0]), 0);
        chk("reset_busy",  32'(dbusy[0]),  0);
        chk("reset_step",  32'(dstep[0]),  0);
        chk("reset_done",  32'(ddone[0]),  0);
        rst = 1'b0;

        // Ascending continuous scan, 4-cycle dwell.
        en = 1'b1; dir = 1'b0;
        ns = 0; nd = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            chk("t1_X", 32'(dx[0]), 32'(((i - 1) / 4) % 8));
            chk("t1_valid", 32'(dvalid[0]), 1);
            if (dstep[0]) ns++;
            if (ddone[0]) nd++;
        end
        chk("t1_step_count", 32'(ns), 10);
        chk("t1_done_count", 32'(nd), 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_idle_valid", 32'(dvalid[0]), 0);
        chk("t1_idle_X_kept", 32'(dx[0]), 1);

        // Descending one-shot sweep.
        dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_first_X", 32'(dx[0]), 7);
        nv = 0; dpos = 0;
        for (int i = 1; i <= 40; i++) begin
            if (dvalid[0]) nv++;
            if (ddone[0] && dpos == 0) dpos = i;
            @(negedge clk);
        end
        chk("t2_valid_cycles", 32'(nv), 32);
        chk("t2_done_pos", 32'(dpos), 33);
        chk("t2_final_X", 32'(dx[0]), 0);
        chk("t2_final_busy", 32'(dbusy[0]), 0);

        // Sweep with a 10-cycle hold at X=3, then ignored start/dir/en.
        en = 1'b1; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy_on_start_en", 32'(dbusy[0]), 1);
        nv = 0; nd = 0; phase = 0; hc = 0;
        for (int i = 1; i <= 70; i++) begin
            if (dvalid[0]) nv++;
            if (ddone[0]) nd++;
            case (phase)
                0: if (dx[0] == 3'd3) begin hold = 1'b1; phase = 1; end
                1: begin
                    chk("t3_frozen_X", 32'(dx[0]), 3);
                    hc++;
                    if (hc == 10) begin
                        hold = 1'b0; start = 1'b1; dir = ~dir; en = 1'b0; phase = 2;
                    end
                end
                2: begin start = 1'b0; phase = 3; end
                default: ;
            endcase
            @(negedge clk);
        end
        chk("t3_valid_cycles", 32'(nv), 42);
        chk("t3_done_count", 32'(nd), 1);
        chk("t3_final_X", 32'(dx[0]), 0);

        // start+en together: sweep first, scan after done.
        en = 1'b1; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy", 32'(dbusy[0]), 1);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (ddone[0]) found = 1;
            @(negedge clk);
        end
        chk("t5_done_seen", 32'(found), 1);
        chk("t5_scan_valid", 32'(dvalid[0]), 1);
        chk("t5_scan_busy",  32'(dbusy[0]),  0);
        chk("t5_scan_step",  32'(dstep[0]),  1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // DIV=1 scan with a direction change mid-scan.
        en = 1'b1; dir = 1'b0;
        @(negedge clk);
        prev = int'(dx[1]); wrap_up = 1'b0; wrap_dn = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) dir = 1'b1;
            @(negedge clk);
            chk("t4_step_div1", 32'(dstep[1]), 1);
            if (i < 12 && prev == 7 && dx[1] == 3'd0) wrap_up = 1'b1;
            if (i >= 13 && prev == 0 && dx[1] == 3'd7) wrap_dn = 1'b1;
            prev = int'(dx[1]);
        end
        chk("t4_wrap_7_to_0", 32'(wrap_up), 1);
        chk("t4_wrap_0_to_7", 32'(wrap_dn), 1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-sweep at X=5.
        dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (dx[0] == 3'd5) found = 1;
            else @(negedge clk);
        end
        chk("t6_reached_5", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_X",     32'(dx[0]),     0);
        chk("t6_rst_valid", 32'(dvalid[0]), 0);
        chk("t6_rst_busy",  32'(dbusy[0]),  0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0; nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (ddone[0]) nd++;
            if (dvalid[0]) nv++;
        end
        chk("t6_no_done", 32'(nd), 0);
        chk("t6_idle_after", 32'(nv), 0);

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 9) < 7);
            dir   = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 11) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end

        en = 1'b0; start = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scan_index_gen
`default_nettype wire
